// File: rtl/mram_serial_ctrl.sv
// Serial host link to async-SRAM-style MRAM bridge: LSB-first address/data shift-in,
// timed MRAM cycle, serial read-back. Define MRAM_SER_PARITY_EN for the address parity check.
module mram_serial_ctrl #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 20,
   parameter int WR_PULSE = 2,
   parameter int RD_LAT   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cmd_we,
   input  logic [1:0]        byte_sel,
   input  logic              ser_addr_in,
   input  logic              ser_data_in,
   output logic              ser_data_out,
   output logic              ser_out_valid,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mram_addr,
   output logic [DATA_W-1:0] mram_dq_out,
   output logic              mram_dq_oe,
   input  logic [DATA_W-1:0] mram_dq_in,
   output logic              chip_en,
   output logic              write_en,
   output logic              out_en,
   output logic              lower_byte_en,
   output logic              upper_byte_en
);

   localparam int N = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
`ifdef MRAM_SER_PARITY_EN
   localparam int SHIFT_LEN = N + 1;
`else
   localparam int SHIFT_LEN = N;
`endif
   localparam int MAX_A   = (SHIFT_LEN > WR_PULSE) ? SHIFT_LEN : WR_PULSE;
   localparam int MAX_B   = (RD_LAT > DATA_W) ? RD_LAT : DATA_W;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_LEN - 1);
   localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_PULSE - 1);
   localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] SER_LAST   = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] ADDR_LIM   = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] DATA_LIM   = CNT_W'(DATA_W);

   typedef enum logic [2:0] {IDLE, SHIFT, SETUP, ACCESS, HOLD, SEROUT, DONE} state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt;
   logic              is_wr;
   logic              sel_lo, sel_hi;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] rd_q;
   logic              par_bad;
   logic              par_err;

`ifdef MRAM_SER_PARITY_EN
   // Sender makes the address plus parity bit even; only meaningful on the last SHIFT cycle.
   assign par_bad = (ser_addr_in != ^addr_q);
`else
   assign par_bad = 1'b0;
`endif

   assign mram_addr   = addr_q;
   assign mram_dq_out = data_q;

   // NOTE: sequential state is written with <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
      state_next = state;
      case (state)
         IDLE:   if (start) state_next = SHIFT;
         SHIFT:  if (cnt == SHIFT_LAST) state_next = par_bad ? DONE : SETUP;
         SETUP:  state_next = ACCESS;
         ACCESS: if (is_wr ? (cnt == WR_LAST) : (cnt == RD_LAST))
                    state_next = is_wr ? HOLD : SEROUT;
         HOLD:   state_next = DONE;
         SEROUT: if (cnt == SER_LAST) state_next = DONE;
         DONE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         is_wr   <= 1'b0;
         sel_lo  <= 1'b0;
         sel_hi  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         rd_q    <= '0;
         par_err <= 1'b0;
      end else begin
         cnt <= (state_next != state || state == IDLE) ? '0 : cnt + CNT_W'(1);
         case (state)
            IDLE: if (start) begin
               is_wr <= cmd_we;
               // 00 selects both bytes; an 8-bit part only has the lower lane.
               if (DATA_W == 8) begin
                  sel_lo <= 1'b1;
                  sel_hi <= 1'b0;
               end else begin
                  sel_lo <= byte_sel[0] | ~byte_sel[1];
                  sel_hi <= byte_sel[1] | ~byte_sel[0];
               end
            end
            SHIFT: begin
               if (cnt < ADDR_LIM)
                  addr_q <= (addr_q >> 1) | (ADDR_W'(ser_addr_in) << (ADDR_W - 1));
               if (is_wr && cnt < DATA_LIM)
                  data_q <= (data_q >> 1) | (DATA_W'(ser_data_in) << (DATA_W - 1));
               if (cnt == SHIFT_LAST)
                  par_err <= par_bad;
            end
            ACCESS: if (!is_wr && cnt == RD_LAST) rd_q <= mram_dq_in;
            SEROUT: rd_q <= rd_q >> 1;
            DONE:   par_err <= 1'b0;
            default: ;
         endcase
      end
   end

   always_comb begin
      chip_en       = 1'b1;
      write_en      = 1'b1;
      out_en        = 1'b1;
      lower_byte_en = 1'b1;
      upper_byte_en = 1'b1;
      mram_dq_oe    = 1'b0;
      busy          = (state != IDLE);
      done          = 1'b0;
      err           = 1'b0;
      ser_data_out  = 1'b0;
      ser_out_valid = 1'b0;
      case (state)
         SETUP, ACCESS, HOLD: begin
            chip_en       = 1'b0;
            lower_byte_en = ~sel_lo;
            upper_byte_en = ~sel_hi;
            mram_dq_oe    = is_wr;
            if (state == ACCESS) begin
               write_en = ~is_wr;
               out_en   = is_wr;
            end
         end
         SEROUT: begin
            ser_data_out  = rd_q[0];
            ser_out_valid = 1'b1;
         end
         DONE: begin
            done = 1'b1;
            err  = par_err;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mram_serial_ctrl.sv
// Directed bench for mram_serial_ctrl: default instance plus an 8-bit/10-bit-address instance.
module tb_mram_serial_ctrl;
`ifdef MRAM_SER_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start0, start1, cmd_we, ser_addr, ser_data;
   logic [1:0]  byte_sel;
   logic [15:0] dq_in0;
   logic [7:0]  dq_in1;

   logic        so0, sv0, busy0, done0, err0, dqoe0, ce0, we0, oen0, lbe0, ube0;
   logic [19:0] addr0;
   logic [15:0] dq0;
   logic        so1, sv1, busy1, done1, err1, dqoe1, ce1, we1, oen1, lbe1, ube1;
   logic [9:0]  addr1;
   logic [7:0]  dq1;

   mram_serial_ctrl dut0 (
      .clk(clk), .rst(rst), .start(start0), .cmd_we(cmd_we), .byte_sel(byte_sel),
      .ser_addr_in(ser_addr), .ser_data_in(ser_data), .ser_data_out(so0),
      .ser_out_valid(sv0), .busy(busy0), .done(done0), .err(err0),
      .mram_addr(addr0), .mram_dq_out(dq0), .mram_dq_oe(dqoe0), .mram_dq_in(dq_in0),
      .chip_en(ce0), .write_en(we0), .out_en(oen0),
      .lower_byte_en(lbe0), .upper_byte_en(ube0)
   );

   mram_serial_ctrl #(.DATA_W(8), .ADDR_W(10), .WR_PULSE(4), .RD_LAT(3)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .cmd_we(cmd_we), .byte_sel(byte_sel),
      .ser_addr_in(ser_addr), .ser_data_in(ser_data), .ser_data_out(so1),
      .ser_out_valid(sv1), .busy(busy1), .done(done1), .err(err1),
      .mram_addr(addr1), .mram_dq_out(dq1), .mram_dq_oe(dqoe1), .mram_dq_in(dq_in1),
      .chip_en(ce1), .write_en(we1), .out_en(oen1),
      .lower_byte_en(lbe1), .upper_byte_en(ube1)
   );

   // Monitor view of whichever instance the current transaction targets.
   int          dsel;
   logic        m_ce, m_we, m_oen, m_lbe, m_ube, m_oe, m_busy, m_done, m_err, m_so, m_sv;
   logic [31:0] m_addr;
   logic [15:0] m_dq;

   always_comb begin
      if (dsel == 1) begin
         {m_ce, m_we, m_oen, m_lbe, m_ube} = {ce1, we1, oen1, lbe1, ube1};
         {m_oe, m_busy, m_done, m_err, m_so, m_sv} = {dqoe1, busy1, done1, err1, so1, sv1};
         m_addr = 32'(addr1);
         m_dq   = 16'(dq1);
      end else begin
         {m_ce, m_we, m_oen, m_lbe, m_ube} = {ce0, we0, oen0, lbe0, ube0};
         {m_oe, m_busy, m_done, m_err, m_so, m_sv} = {dqoe0, busy0, done0, err0, so0, sv0};
         m_addr = 32'(addr0);
         m_dq   = dq0;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Per-transaction observations; cycle 0 is the start cycle.
   int          r_done, r_we_first, r_we_cnt, r_oen_first, r_oen_cnt;
   int          r_ser_first, r_ser_cnt, r_err_cyc, r_busy_bad;
   logic [15:0] r_ser, r_dq;
   logic [31:0] r_addr;
   logic [1:0]  r_be;
   bit          r_be_var, r_ce_seen, r_ube_low, r_dqoe_seen, r_overlap, r_rst_ok;

   task automatic run_txn(input int d, input bit we, input logic [1:0] sel,
                          input logic [31:0] a, input logic [31:0] wd, input logic [15:0] rd,
                          input bit bad_par, input int xs1, input int xs2, input int rst_cyc);
      int aw, dw, n;
      bit fin;
      aw = (d == 1) ? 10 : 20;
      dw = (d == 1) ? 8 : 16;
      n  = (aw > dw) ? aw : dw;
      dsel = d;
      r_done = -1; r_we_first = -1; r_we_cnt = 0; r_oen_first = -1; r_oen_cnt = 0;
      r_ser_first = -1; r_ser_cnt = 0; r_err_cyc = -1; r_busy_bad = 0;
      r_ser = '0; r_dq = '0; r_addr = '0; r_be = '0;
      r_be_var = 0; r_ce_seen = 0; r_ube_low = 0; r_dqoe_seen = 0; r_overlap = 0; r_rst_ok = 0;

      @(negedge clk);
      if (m_busy) r_busy_bad++;
      cmd_we   = we;
      byte_sel = sel;
      if (d == 1) start1 = 1'b1; else start0 = 1'b1;
      fin = 0;
      for (int c = 1; c <= 80 && !fin; c++) begin
         @(negedge clk);
         if (r_done >= 0) begin
            if (m_busy || m_done) r_busy_bad++;
            fin = 1;
         end else begin
            if (!m_busy) r_busy_bad++;
            if (!m_we) begin
               if (r_we_cnt == 0) begin r_we_first = c; r_dq = m_dq; end
               r_we_cnt++;
            end
            if (!m_oen) begin
               if (r_oen_cnt == 0) r_oen_first = c;
               r_oen_cnt++;
            end
            if (!m_we && !m_oen) r_overlap = 1;
            if (m_oe) r_dqoe_seen = 1;
            if (!m_ube) r_ube_low = 1;
            if (!m_ce) begin
               if (!r_ce_seen) begin r_addr = m_addr; r_be = {m_ube, m_lbe}; end
               else if ({m_ube, m_lbe} != r_be) r_be_var = 1;
               r_ce_seen = 1;
            end
            if (m_sv) begin
               if (r_ser_cnt == 0) r_ser_first = c;
               if (r_ser_cnt < 16) r_ser[r_ser_cnt] = m_so;
               r_ser_cnt++;
            end
            if (m_err) r_err_cyc = c;
            if (m_done) r_done = c;
         end
         // Drive inputs for cycle c; MRAM model returns rd only while out_en is low.
         start0 = 1'b0;
         start1 = 1'b0;
         if (c == xs1 || c == xs2) begin
            if (d == 1) start1 = 1'b1; else start0 = 1'b1;
         end
         ser_addr = 1'b1;
         ser_data = 1'b1;
         if (c <= n) begin
            ser_addr = a[c-1];
            ser_data = wd[c-1];
         end else if (P == 1 && c == n + 1) begin
            ser_addr = (^a) ^ bad_par;
         end
         dq_in0 = m_oen ? ~rd : rd;
         dq_in1 = m_oen ? ~rd[7:0] : rd[7:0];
         if (c == rst_cyc) begin
            rst = 1'b1;
            #1;
            r_rst_ok = m_ce & m_we & m_oen & m_lbe & m_ube & ~m_oe & ~m_busy & ~m_done;
            @(negedge clk);
            rst = 1'b0;
            fin = 1;
         end
      end
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; cmd_we = 1'b0; byte_sel = 2'b00;
      ser_addr = 1'b0; ser_data = 1'b0; dq_in0 = '0; dq_in1 = '0; dsel = 0;
      repeat (2) @(negedge clk);
      check("rst0_strobes", {ce0, we0, oen0, lbe0, ube0}, 5'h1F);
      check("rst0_flags", {dqoe0, busy0, done0, err0, sv0, so0}, 6'h00);
      check("rst0_addr", addr0, 0);
      check("rst0_dq", dq0, 0);
      check("rst1_strobes", {ce1, we1, oen1, lbe1, ube1}, 5'h1F);
      check("rst1_flags", {dqoe1, busy1, done1, err1, sv1, so1}, 6'h00);
      rst = 1'b0;

      // Write, both bytes, 10 ones then 10 zeros on both serial lines.
      run_txn(0, 1, 2'b11, 32'h003FF, 32'h003FF, 16'h0, 0, -1, -1, -1);
      check("A_done", r_done, 25 + P);
      check("A_we_first", r_we_first, 22 + P);
      check("A_we_cnt", r_we_cnt, 2);
      check("A_oen_cnt", r_oen_cnt, 0);
      check("A_addr", r_addr, 32'h003FF);
      check("A_dq", r_dq, 16'h03FF);
      check("A_be", {r_be_var, r_be}, 3'b000);
      check("A_dqoe", r_dqoe_seen, 1);
      check("A_busy", r_busy_bad, 0);
      check("A_err", r_err_cyc, -1);

      // Read, alternating address bits, MRAM returns 0x5555.
      run_txn(0, 0, 2'b11, 32'hAAAAA, 32'h0, 16'h5555, 0, -1, -1, -1);
      check("B_addr", r_addr, 32'hAAAAA);
      check("B_oen_first", r_oen_first, 22 + P);
      check("B_oen_cnt", r_oen_cnt, 2);
      check("B_we_cnt", r_we_cnt, 0);
      check("B_ser_first", r_ser_first, 24 + P);
      check("B_ser_cnt", r_ser_cnt, 16);
      check("B_ser", r_ser, 16'h5555);
      check("B_done", r_done, 40 + P);
      check("B_dqoe", r_dqoe_seen, 0);
      check("B_overlap", r_overlap, 0);
      check("B_busy", r_busy_bad, 0);

      // Lower byte only; data bits beyond 16 must be dropped.
      run_txn(0, 1, 2'b01, 32'h12345, 32'hFBEEF, 16'h0, 0, -1, -1, -1);
      check("C_be", {r_be_var, r_be}, 3'b010);
      check("C_addr", r_addr, 32'h12345);
      check("C_dq", r_dq, 16'hBEEF);
      check("C_done", r_done, 25 + P);

      // byte_sel 00 means both; starts during SHIFT and during DONE are ignored.
      run_txn(0, 1, 2'b00, 32'h00001, 32'h08001, 16'h0, 0, 5, 25 + P, -1);
      check("D_be", {r_be_var, r_be}, 3'b000);
      check("D_dq", r_dq, 16'h8001);
      check("D_done", r_done, 25 + P);
      check("D_busy", r_busy_bad, 0);

      // Reset asserted during ACCESS, then a normal read.
      run_txn(0, 0, 2'b11, 32'h54321, 32'h0, 16'h1234, 0, -1, -1, 22 + P);
      check("E_rst_ok", r_rst_ok, 1);
      check("E_addr_cleared", addr0, 0);
      run_txn(0, 0, 2'b10, 32'h0F0F0, 32'h0, 16'hA5C3, 0, -1, -1, -1);
      check("F_ser", r_ser, 16'hA5C3);
      check("F_done", r_done, 40 + P);
      check("F_be", {r_be_var, r_be}, 3'b001);
      check("F_busy", r_busy_bad, 0);

      // Narrow instance: 4-cycle write pulse, data bits 8 and 9 ignored.
      run_txn(1, 1, 2'b11, 32'h2AB, 32'h3FF, 16'h0, 0, -1, -1, -1);
      check("G_we_first", r_we_first, 12 + P);
      check("G_we_cnt", r_we_cnt, 4);
      check("G_addr", r_addr, 32'h2AB);
      check("G_dq", r_dq, 16'h00FF);
      check("G_ube_low", r_ube_low, 0);
      check("G_be", {r_be_var, r_be}, 3'b010);
      check("G_done", r_done, 17 + P);

      // Narrow instance read: 3-cycle out_en, 8 serial bits.
      run_txn(1, 0, 2'b11, 32'h155, 32'h0, 16'h0096, 0, -1, -1, -1);
      check("H_oen_first", r_oen_first, 12 + P);
      check("H_oen_cnt", r_oen_cnt, 3);
      check("H_ser_first", r_ser_first, 15 + P);
      check("H_ser_cnt", r_ser_cnt, 8);
      check("H_ser", r_ser, 16'h0096);
      check("H_ube_low", r_ube_low, 0);
      check("H_done", r_done, 23 + P);

`ifdef MRAM_SER_PARITY_EN
      // Bad parity: err and done together right after SHIFT, no MRAM cycle.
      run_txn(0, 1, 2'b11, 32'h003FF, 32'h003FF, 16'h0, 1, -1, -1, -1);
      check("P_done", r_done, 22);
      check("P_err", r_err_cyc, 22);
      check("P_ce_seen", r_ce_seen, 0);
      check("P_we_cnt", r_we_cnt, 0);
      run_txn(0, 1, 2'b11, 32'h003FF, 32'h003FF, 16'h0, 0, -1, -1, -1);
      check("P_good_done", r_done, 26);
      check("P_good_err", r_err_cyc, -1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
